sprite_frame_compositor: RTL and testbench
==========================================

// Module: sprite_frame_compositor
// PURPOSE
//  Display-side consumer of the game-logic sprite interface (positions, pacman_is_dead, pacman direction).
//  Latches all sprite state once per frame, hit-tests each scanned pixel against 5 sprite boxes.
//  Outputs priority-muxed 12-bit RGB over the background with a fixed 2-cycle pipeline.
//  Sequences the pacman death-flash animation; sits between game logic and the VGA output stage.
// PARAMETERS
//  SPRITE_W      16   sprite box width, pixels (power of 2, >=4)
//  SPRITE_H      16   sprite box height, pixels (power of 2, >=4)
//  H_ACTIVE      1280 visible width; sprite x >= H_ACTIVE => sprite hidden
//  V_ACTIVE      1024 visible height; sprite y >= V_ACTIVE => sprite hidden
//  FLASH_FRAMES  8    frames per death-flash phase
//  FLASH_PHASES  6    number of phases before death animation completes
// PORTS
//  clk              in   1   pixel clock
//  rst              in   1   synchronous active-high reset
//  frame_start      in   1   1-cycle pulse at start of vblank; shadow-register load strobe
//  pix_valid        in   1   pix_x/pix_y/bg_rgb valid (active video)
//  pix_x            in   11  current pixel column
//  pix_y            in   10  current pixel row
//  bg_rgb           in   12  background/maze colour for this pixel
//  pacman_pos_x/_y  in   11/10  pacman top-left (same for blinky/pinky/inky/clyde _pos_x/_pos_y)
//  pacman_is_dead   in   1   collision flag from game logic
//  pacman_moving_dir in  4   one-hot dir: RIGHT=0001 UP=0010 DOWN=0100 LEFT=1000
//  rgb_out          out  12  composited colour
//  rgb_valid        out  1   pix_valid delayed 2 cycles
//  sprite_hit_id    out  3   0=none,1=pacman,2=blinky,3=pinky,4=inky,5=clyde (aligned with rgb_out)
//  death_anim_done  out  1   high in DONE state
// BEHAVIOUR
//  Reset: rgb_out=0, rgb_valid=0, sprite_hit_id=0, death_anim_done=0, FSM=IDLE, counters=0,
//   shadow positions=0, shadow dir=RIGHT, sprites_en=0 (all sprites hidden until first frame_start).
//  Shadow: on frame_start latch all 10 position inputs, pacman_is_dead, set sprites_en=1.
//   Dir latched only if one-hot; 0 or multi-hot keeps previous shadow dir. Rendering uses shadow only.
//  Stage 1 (cycle N+1): per sprite hit = en && sx<H_ACTIVE && sy<V_ACTIVE && px>=sx && px<sx+SPRITE_W
//   && py>=sy && py<sy+SPRITE_H; sums in 12/11 bits (no wrap; boxes clip at right/bottom edge).
//   Register local offsets lx=px-sx, ly=py-sy for pacman, bg_rgb, pix_valid.
//  Stage 2 (cycle N+2): priority pacman>blinky>pinky>inky>clyde>bg. Colours: pacman 12'hFF0,
//   blinky 12'hF00, pinky 12'hF8C, inky 12'h0FF, clyde 12'hF80.
//  Pacman mouth (transparent, falls to next priority): mid rows ly in [H/4,3H/4) with
//   RIGHT lx>=3W/4, LEFT lx<W/4; UP/DOWN same on columns using ly<H/4 / ly>=3H/4.
//  pacman_visible gates pacman hit: 1 in IDLE, phase_cnt[0]==0 in FLASH, 0 in DONE.
//  !pix_valid at stage 2 => rgb_out=0, sprite_hit_id=0, rgb_valid=0.
//  Death FSM, advances only on frame_start (after shadow load):
//   IDLE : shadow dead=1 -> FLASH, frame_cnt=0, phase_cnt=0.
//   FLASH: frame_cnt++; at FLASH_FRAMES-1 wrap to 0, phase_cnt++; phase_cnt reaching FLASH_PHASES -> DONE.
//          dead deasserts -> IDLE (abort).
//   DONE : death_anim_done=1; dead deasserts -> IDLE.
//  frame_start coincident with pix_valid: shadow update takes effect on the next pixel; in-flight pipeline unaffected.
//  rst mid-frame: pipeline flushed, rgb_valid=0 next cycle, all sprites hidden until next frame_start.
// TESTING
//  1 rst, frame_start with pinky=(615,258); scan (615,258) -> 2 cycles later rgb_out=F8C, hit_id=3, rgb_valid=1.
//  2 pacman and blinky both at (100,100); pixel (101,101) -> FF0 id=1; pixel (115,108) dir RIGHT -> F00 id=2 (mouth).
//  3 change pinky_pos mid-frame without frame_start -> rendering unchanged until next frame_start.
//  4 sprite x=1270, W=16 -> pixels 1270..1279 hit; x=1280 -> never hit; x=2047 no wrap to column 0.
//  5 dead=1 held: pacman shown frames 0-7, hidden 8-15, ..., death_anim_done=1 after 48 frames; dead=0 -> IDLE.
//  6 dir=0000 or 0011 -> mouth keeps previous direction; rst during FLASH -> IDLE, outputs 0.

Source files
------------

// File: rtl/sprite_frame_compositor.sv
// Sprite compositor: per-frame shadow of game-logic sprite state, 5-box hit test,
// priority colour mux over background (2-cycle pipeline) and pacman death-flash FSM.
module sprite_frame_compositor #(
    parameter int SPRITE_W     = 16,
    parameter int SPRITE_H     = 16,
    parameter int H_ACTIVE     = 1280,
    parameter int V_ACTIVE     = 1024,
    parameter int FLASH_FRAMES = 8,
    parameter int FLASH_PHASES = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [10:0] pix_x,
    input  logic [9:0]  pix_y,
    input  logic [11:0] bg_rgb,
    input  logic [10:0] pacman_pos_x,
    input  logic [9:0]  pacman_pos_y,
    input  logic [10:0] blinky_pos_x,
    input  logic [9:0]  blinky_pos_y,
    input  logic [10:0] pinky_pos_x,
    input  logic [9:0]  pinky_pos_y,
    input  logic [10:0] inky_pos_x,
    input  logic [9:0]  inky_pos_y,
    input  logic [10:0] clyde_pos_x,
    input  logic [9:0]  clyde_pos_y,
    input  logic        pacman_is_dead,
    input  logic [3:0]  pacman_moving_dir,
    output logic [11:0] rgb_out,
    output logic        rgb_valid,
    output logic [2:0]  sprite_hit_id,
    output logic        death_anim_done
);
    localparam int LXW = $clog2(SPRITE_W);
    localparam int LYW = $clog2(SPRITE_H);
    localparam int FCW = $clog2(FLASH_FRAMES + 1);
    localparam int PCW = $clog2(FLASH_PHASES + 1);

    typedef enum logic [1:0] {IDLE, FLASH, DONE} state_t;

    logic [10:0] pos_x_in [5];
    logic [9:0]  pos_y_in [5];
    logic [10:0] sx_q [5], sx_d [5];
    logic [9:0]  sy_q [5], sy_d [5];
    logic        dead_q, dead_d;
    logic [3:0]  dir_q, dir_d;
    logic        en_q, en_d;

    state_t         state_q, state_d;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic [PCW-1:0] phase_cnt_q, phase_cnt_d;
    logic           done_q, done_d;

    logic [4:0]     s1_hit_q, s1_hit_d;
    logic [LXW-1:0] s1_lx_q, s1_lx_d;
    logic [LYW-1:0] s1_ly_q, s1_ly_d;
    logic [11:0]    s1_bg_q;
    logic           s1_valid_q;
    logic [3:0]     s1_dir_q;
    logic           s1_vis_q, s1_vis_d;

    logic [11:0] rgb_q, rgb_d;
    logic        valid_q;
    logic [2:0]  id_q, id_d;

    logic [10:0] dx;
    logic [9:0]  dy;
    logic        mid_x, mid_y, mouth, pac_hit;

    always_comb begin
        pos_x_in = '{pacman_pos_x, blinky_pos_x, pinky_pos_x, inky_pos_x, clyde_pos_x};
        pos_y_in = '{pacman_pos_y, blinky_pos_y, pinky_pos_y, inky_pos_y, clyde_pos_y};
        sx_d   = sx_q;
        sy_d   = sy_q;
        dead_d = dead_q;
        dir_d  = dir_q;
        en_d   = en_q;
        if (frame_start) begin
            sx_d   = pos_x_in;
            sy_d   = pos_y_in;
            dead_d = pacman_is_dead;
            en_d   = 1'b1;
            if (pacman_moving_dir != 4'b0 &&
                (pacman_moving_dir & (pacman_moving_dir - 4'd1)) == 4'b0)
                dir_d = pacman_moving_dir;
        end
    end

    // Sums are widened by one bit so boxes near the right/bottom edge clip instead of wrapping.
    always_comb begin
        s1_hit_d = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            s1_hit_d[i] = en_q
                && ({1'b0, sx_q[i]} < 12'(H_ACTIVE))
                && ({1'b0, sy_q[i]} < 11'(V_ACTIVE))
                && (pix_x >= sx_q[i])
                && ({1'b0, pix_x} < ({1'b0, sx_q[i]} + 12'(SPRITE_W)))
                && (pix_y >= sy_q[i])
                && ({1'b0, pix_y} < ({1'b0, sy_q[i]} + 11'(SPRITE_H)));
        end
        dx      = pix_x - sx_q[0];
        dy      = pix_y - sy_q[0];
        s1_lx_d = dx[LXW-1:0];
        s1_ly_d = dy[LYW-1:0];
        case (state_q)
            IDLE:    s1_vis_d = 1'b1;
            FLASH:   s1_vis_d = ~phase_cnt_q[0];
            default: s1_vis_d = 1'b0;
        endcase
    end

    always_comb begin
        mid_x = (s1_lx_q >= LXW'(SPRITE_W / 4)) && (s1_lx_q < LXW'(3 * SPRITE_W / 4));
        mid_y = (s1_ly_q >= LYW'(SPRITE_H / 4)) && (s1_ly_q < LYW'(3 * SPRITE_H / 4));
        case (s1_dir_q)
            4'b0001: mouth = mid_y && (s1_lx_q >= LXW'(3 * SPRITE_W / 4));
            4'b0010: mouth = mid_x && (s1_ly_q <  LYW'(SPRITE_H / 4));
            4'b0100: mouth = mid_x && (s1_ly_q >= LYW'(3 * SPRITE_H / 4));
            4'b1000: mouth = mid_y && (s1_lx_q <  LXW'(SPRITE_W / 4));
            default: mouth = 1'b0;
        endcase
        pac_hit = s1_hit_q[0] && s1_vis_q && !mouth;
        rgb_d   = '0;
        id_d    = '0;
        if (s1_valid_q) begin
            if (pac_hit)          begin rgb_d = 12'hFF0; id_d = 3'd1; end
            else if (s1_hit_q[1]) begin rgb_d = 12'hF00; id_d = 3'd2; end
            else if (s1_hit_q[2]) begin rgb_d = 12'hF8C; id_d = 3'd3; end
            else if (s1_hit_q[3]) begin rgb_d = 12'h0FF; id_d = 3'd4; end
            else if (s1_hit_q[4]) begin rgb_d = 12'hF80; id_d = 3'd5; end
            else                  rgb_d = s1_bg_q;
        end
    end

    // FSM decisions use the dead flag being latched on this same frame_start.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        phase_cnt_d = phase_cnt_q;
        if (frame_start) begin
            case (state_q)
                IDLE: if (dead_d) begin
                    state_d     = FLASH;
                    frame_cnt_d = '0;
                    phase_cnt_d = '0;
                end
                FLASH: begin
                    if (!dead_d) begin
                        state_d = IDLE;
                    end else if (frame_cnt_q == FCW'(FLASH_FRAMES - 1)) begin
                        frame_cnt_d = '0;
                        phase_cnt_d = phase_cnt_q + 1'b1;
                        if (phase_cnt_q == PCW'(FLASH_PHASES - 1)) state_d = DONE;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
                default: if (!dead_d) state_d = IDLE;
            endcase
        end
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sx_q        <= '{default: '0};
            sy_q        <= '{default: '0};
            dead_q      <= 1'b0;
            dir_q       <= 4'b0001;
            en_q        <= 1'b0;
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            phase_cnt_q <= '0;
            done_q      <= 1'b0;
            s1_hit_q    <= '0;
            s1_lx_q     <= '0;
            s1_ly_q     <= '0;
            s1_bg_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_dir_q    <= 4'b0001;
            s1_vis_q    <= 1'b0;
            rgb_q       <= '0;
            valid_q     <= 1'b0;
            id_q        <= '0;
        end else begin
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            dead_q      <= dead_d;
            dir_q       <= dir_d;
            en_q        <= en_d;
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            phase_cnt_q <= phase_cnt_d;
            done_q      <= done_d;
            s1_hit_q    <= s1_hit_d;
            s1_lx_q     <= s1_lx_d;
            s1_ly_q     <= s1_ly_d;
            s1_bg_q     <= bg_rgb;
            s1_valid_q  <= pix_valid;
            s1_dir_q    <= dir_q;
            s1_vis_q    <= s1_vis_d;
            rgb_q       <= rgb_d;
            valid_q     <= s1_valid_q;
            id_q        <= id_d;
        end
    end

    assign rgb_out         = rgb_q;
    assign rgb_valid       = valid_q;
    assign sprite_hit_id   = id_q;
    assign death_anim_done = done_q;
endmodule

// File: tb/tb_sprite_frame_compositor.sv
// Directed bench for sprite_frame_compositor: hit test, priority, mouth, shadow timing, death flash.
module tb_sprite_frame_compositor;
    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        pix_valid;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic [11:0] bg_rgb;
    logic [10:0] pacman_pos_x, blinky_pos_x, pinky_pos_x, inky_pos_x, clyde_pos_x;
    logic [9:0]  pacman_pos_y, blinky_pos_y, pinky_pos_y, inky_pos_y, clyde_pos_y;
    logic        pacman_is_dead;
    logic [3:0]  pacman_moving_dir;
    logic [11:0] rgb_out;
    logic        rgb_valid;
    logic [2:0]  sprite_hit_id;
    logic        death_anim_done;

    int checks = 0;
    int errors = 0;

    sprite_frame_compositor #(
        .SPRITE_W(16), .SPRITE_H(16), .H_ACTIVE(1280), .V_ACTIVE(1024),
        .FLASH_FRAMES(8), .FLASH_PHASES(6)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
        .pix_x(pix_x), .pix_y(pix_y), .bg_rgb(bg_rgb),
        .pacman_pos_x(pacman_pos_x), .pacman_pos_y(pacman_pos_y),
        .blinky_pos_x(blinky_pos_x), .blinky_pos_y(blinky_pos_y),
        .pinky_pos_x(pinky_pos_x), .pinky_pos_y(pinky_pos_y),
        .inky_pos_x(inky_pos_x), .inky_pos_y(inky_pos_y),
        .clyde_pos_x(clyde_pos_x), .clyde_pos_y(clyde_pos_y),
        .pacman_is_dead(pacman_is_dead), .pacman_moving_dir(pacman_moving_dir),
        .rgb_out(rgb_out), .rgb_valid(rgb_valid),
        .sprite_hit_id(sprite_hit_id), .death_anim_done(death_anim_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fs();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic probe(input string tag, input logic [10:0] x, input logic [9:0] y,
                         input logic [11:0] bg, input logic with_fs,
                         input logic [11:0] exp_rgb, input logic [2:0] exp_id);
        pix_x = x; pix_y = y; bg_rgb = bg; pix_valid = 1'b1; frame_start = with_fs;
        @(posedge clk); #1;
        pix_valid = 1'b0; frame_start = 1'b0;
        @(posedge clk); #1;
        check({tag, ".valid"}, 12'(rgb_valid), 12'h001);
        check({tag, ".rgb"}, rgb_out, exp_rgb);
        check({tag, ".id"}, 12'(sprite_hit_id), 12'(exp_id));
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0;
        pix_x = '0; pix_y = '0; bg_rgb = '0;
        pacman_pos_x = 11'd2000; pacman_pos_y = '0;
        blinky_pos_x = 11'd2000; blinky_pos_y = '0;
        pinky_pos_x  = 11'd2000; pinky_pos_y  = '0;
        inky_pos_x   = 11'd2000; inky_pos_y   = '0;
        clyde_pos_x  = 11'd2000; clyde_pos_y  = '0;
        pacman_is_dead = 1'b0; pacman_moving_dir = 4'b0001;
        repeat (3) @(posedge clk);
        #1;
        check("rst.rgb", rgb_out, 12'h000);
        check("rst.valid", 12'(rgb_valid), 12'h000);
        check("rst.id", 12'(sprite_hit_id), 12'h000);
        check("rst.done", 12'(death_anim_done), 12'h000);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle.valid", 12'(rgb_valid), 12'h000);

        // Sprites hidden until the first frame_start
        pinky_pos_x = 11'd615; pinky_pos_y = 10'd258;
        probe("pre_fs", 11'd615, 10'd258, 12'h123, 1'b0, 12'h123, 3'd0);
        fs();
        probe("pinky", 11'd615, 10'd258, 12'h123, 1'b0, 12'hF8C, 3'd3);

        // Overlap priority and RIGHT mouth
        pacman_pos_x = 11'd100; pacman_pos_y = 10'd100;
        blinky_pos_x = 11'd100; blinky_pos_y = 10'd100;
        fs();
        probe("pac_over_blinky", 11'd101, 10'd101, 12'h00A, 1'b0, 12'hFF0, 3'd1);
        probe("mouth_right", 11'd115, 10'd108, 12'h00A, 1'b0, 12'hF00, 3'd2);
        probe("mouth_edge12", 11'd112, 10'd108, 12'h00A, 1'b0, 12'hF00, 3'd2);
        probe("mouth_edge11", 11'd111, 10'd108, 12'h00A, 1'b0, 12'hFF0, 3'd1);
        probe("mouth_row12", 11'd115, 10'd112, 12'h00A, 1'b0, 12'hFF0, 3'd1);

        // Shadow registers hold until frame_start; coincident pixel uses old shadow
        pinky_pos_x = 11'd0; pinky_pos_y = 10'd0;
        probe("shadow_old", 11'd615, 10'd258, 12'h055, 1'b0, 12'hF8C, 3'd3);
        probe("shadow_new_not_yet", 11'd0, 10'd0, 12'h055, 1'b0, 12'h055, 3'd0);
        probe("fs_coincident", 11'd0, 10'd0, 12'h055, 1'b1, 12'h055, 3'd0);
        probe("shadow_new", 11'd0, 10'd0, 12'h055, 1'b0, 12'hF8C, 3'd3);
        probe("shadow_old_gone", 11'd615, 10'd258, 12'h055, 1'b0, 12'h055, 3'd0);

        // Right-edge clipping, hidden at x=H_ACTIVE, no wrap from x=2047
        inky_pos_x = 11'd1270; inky_pos_y = 10'd500;
        clyde_pos_x = 11'd1280; clyde_pos_y = 10'd600;
        fs();
        probe("inky_left", 11'd1270, 10'd500, 12'h0A0, 1'b0, 12'h0FF, 3'd4);
        probe("inky_1279", 11'd1279, 10'd500, 12'h0A0, 1'b0, 12'h0FF, 3'd4);
        probe("inky_1269", 11'd1269, 10'd500, 12'h0A0, 1'b0, 12'h0A0, 3'd0);
        probe("clyde_1280", 11'd1285, 10'd600, 12'h0A0, 1'b0, 12'h0A0, 3'd0);
        clyde_pos_x = 11'd2047;
        fs();
        probe("clyde_nowrap0", 11'd0, 10'd600, 12'h0A0, 1'b0, 12'h0A0, 3'd0);
        probe("clyde_nowrap14", 11'd14, 10'd600, 12'h0A0, 1'b0, 12'h0A0, 3'd0);
        probe("clyde_2047", 11'd2047, 10'd600, 12'h0A0, 1'b0, 12'h0A0, 3'd0);

        // Death flash: 6 phases of 8 frames, visible on even phases
        blinky_pos_x = 11'd2000;
        pacman_is_dead = 1'b1;
        fs();
        for (int k = 0; k < 48; k++) begin
            if (((k / 8) % 2) == 0)
                probe($sformatf("flash_f%0d", k), 11'd101, 10'd101, 12'h00A, 1'b0, 12'hFF0, 3'd1);
            else
                probe($sformatf("flash_f%0d", k), 11'd101, 10'd101, 12'h00A, 1'b0, 12'h00A, 3'd0);
            check($sformatf("flash_done_f%0d", k), 12'(death_anim_done), 12'h000);
            fs();
        end
        check("done_set", 12'(death_anim_done), 12'h001);
        probe("done_hidden", 11'd101, 10'd101, 12'h00A, 1'b0, 12'h00A, 3'd0);
        pacman_is_dead = 1'b0;
        fs();
        check("done_clear", 12'(death_anim_done), 12'h000);
        probe("idle_visible", 11'd101, 10'd101, 12'h00A, 1'b0, 12'hFF0, 3'd1);

        // Direction latched only when one-hot
        pacman_moving_dir = 4'b0010;
        fs();
        probe("mouth_up", 11'd108, 10'd100, 12'h00A, 1'b0, 12'h00A, 3'd0);
        pacman_moving_dir = 4'b0000;
        fs();
        probe("dir_zero_keeps", 11'd108, 10'd100, 12'h00A, 1'b0, 12'h00A, 3'd0);
        pacman_moving_dir = 4'b0011;
        fs();
        probe("dir_multi_keeps", 11'd108, 10'd100, 12'h00A, 1'b0, 12'h00A, 3'd0);
        probe("dir_multi_noright", 11'd115, 10'd108, 12'h00A, 1'b0, 12'hFF0, 3'd1);
        pacman_moving_dir = 4'b1000;
        fs();
        probe("mouth_left", 11'd100, 10'd108, 12'h00A, 1'b0, 12'h00A, 3'd0);
        probe("left_top_solid", 11'd108, 10'd100, 12'h00A, 1'b0, 12'hFF0, 3'd1);

        // Reset during FLASH (phase 1, pacman hidden) with a pixel in flight
        pacman_moving_dir = 4'b0001;
        pacman_is_dead = 1'b1;
        fs();
        repeat (8) fs();
        probe("flash_ph1", 11'd101, 10'd101, 12'h00A, 1'b0, 12'h00A, 3'd0);
        pix_x = 11'd101; pix_y = 10'd101; bg_rgb = 12'h00A; pix_valid = 1'b1;
        @(posedge clk); #1;
        pix_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid.valid", 12'(rgb_valid), 12'h000);
        check("rst_mid.rgb", rgb_out, 12'h000);
        check("rst_mid.id", 12'(sprite_hit_id), 12'h000);
        check("rst_mid.done", 12'(death_anim_done), 12'h000);
        rst = 1'b0;
        @(posedge clk); #1;
        probe("post_rst_hidden", 11'd101, 10'd101, 12'h00A, 1'b0, 12'h00A, 3'd0);
        fs();
        probe("post_rst_phase0", 11'd101, 10'd101, 12'h00A, 1'b0, 12'hFF0, 3'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
